// File: rtl/mm_bank_pkg.sv
// Shared types and constants for the m10k bank read path.
package mm_bank_pkg;

   localparam int unsigned BANK_W            = 32;
   localparam int unsigned M10K_READ_LATENCY = 3;

   typedef logic [BANK_W-1:0] bank_word_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } stream_state_e;

endpackage

// File: rtl/bank_rd_fifo.sv
// Synchronous first-word-fall-through FIFO holding returned bank rows.
module bank_rd_fifo #(
   parameter  int unsigned DEPTH = 4,
   parameter  int unsigned DW    = 129,
   localparam int unsigned CW    = $clog2(DEPTH + 1),
   localparam int unsigned PW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [DW-1:0] pop_data,
   output logic [CW-1:0] count,
   output logic          empty
);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign pop_data = mem[rd_ptr];
   assign empty    = (count == '0);

endmodule

// File: rtl/bank_read_streamer.sv
// Streams consecutive rows from all m10k banks as valid/ready beats.
// Optional stall_cycles counter enabled by BANK_STREAM_STALL_CNT_EN.
module bank_read_streamer
   import mm_bank_pkg::*;
#(
   parameter  int unsigned N_BANKS        = 4,
   parameter  int unsigned W              = BANK_W,
   parameter  int unsigned DEPTH_PER_BANK = 16,
   parameter  int unsigned READ_LATENCY   = M10K_READ_LATENCY,
   parameter  int unsigned FIFO_DEPTH     = 4,
   localparam int unsigned AW             = $clog2(DEPTH_PER_BANK)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [AW-1:0]         base_addr,
   input  logic [AW:0]           count,
   output logic                  busy,
   output logic                  done,
   output logic [N_BANKS-1:0]    b_en,
   output logic [N_BANKS*AW-1:0] b_addr,
   input  logic [N_BANKS*W-1:0]  b_dout,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [N_BANKS*W-1:0]  m_data,
   output logic                  m_last
`ifdef BANK_STREAM_STALL_CNT_EN
   ,
   output logic [31:0]           stall_cycles
`endif
);

   localparam int unsigned DW = N_BANKS * W;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   if (FIFO_DEPTH < 2) begin : g_bad_fifo_depth
      $error("bank_read_streamer: FIFO_DEPTH must be at least 2");
   end

   stream_state_e           state_q, state_d;
   logic                    issue_c, last_c;
   logic [AW-1:0]           issue_addr_c;
   logic [AW:0]             cur_idx_c, cur_cnt_c;
   logic [31:0]             occ_c;
   logic [AW-1:0]           addr_q, b_addr_q;
   logic [AW:0]             issued_q, count_q;
   logic                    en_q, last_q;
   logic [READ_LATENCY-1:0] pipe_v, pipe_l;
   logic [CW-1:0]           fifo_count;
   logic                    fifo_empty, pop_c;
   logic [DW:0]             fifo_out;

   function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
      return (a == AW'(DEPTH_PER_BANK - 1)) ? '0 : a + AW'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Issue decision: every read in flight (b_en stage, pipe, FIFO) holds a FIFO slot.
   always_comb begin
      state_d      = state_q;
      issue_c      = 1'b0;
      cur_idx_c    = (state_q == IDLE) ? '0 : issued_q;
      cur_cnt_c    = (state_q == IDLE) ? count : count_q;
      issue_addr_c = (state_q == IDLE) ? base_addr : addr_q;
      last_c       = ((cur_idx_c + (AW+1)'(1)) == cur_cnt_c);
      occ_c        = 32'(en_q) + 32'($countones(pipe_v)) + 32'(fifo_count) - 32'(pop_c);
      case (state_q)
         IDLE: begin
            if (start) begin
               if (count == '0) begin
                  state_d = DONE;
               end else begin
                  issue_c = 1'b1;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (issued_q == count_q) begin
               state_d = DRAIN;
            end else if (occ_c < FIFO_DEPTH) begin
               issue_c = 1'b1;
               if (last_c) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (fifo_empty && !en_q && (pipe_v == '0)) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q   <= '0;
         b_addr_q <= '0;
         issued_q <= '0;
         count_q  <= '0;
         en_q     <= 1'b0;
         last_q   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         en_q   <= issue_c;
         last_q <= issue_c & last_c;
         busy   <= (state_d == RUN) || (state_d == DRAIN);
         done   <= (state_d == DONE);
         if (state_q == IDLE && start) count_q <= count;
         if (issue_c) begin
            b_addr_q <= issue_addr_c;
            addr_q   <= addr_inc(issue_addr_c);
            issued_q <= cur_idx_c + (AW+1)'(1);
         end else if (state_q == IDLE) begin
            issued_q <= '0;
         end
      end
   end

   // Valid/last shift register matching the bank read latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_v <= '0;
         pipe_l <= '0;
      end else begin
         pipe_v[0] <= en_q;
         pipe_l[0] <= en_q & last_q;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_l[i] <= pipe_l[i-1];
         end
      end
   end

   bank_rd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .DW    (DW + 1)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (pipe_v[READ_LATENCY-1]),
      .push_data ({pipe_l[READ_LATENCY-1], b_dout}),
      .pop       (pop_c),
      .pop_data  (fifo_out),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   assign pop_c   = m_valid & m_ready;
   assign m_valid = ~fifo_empty;
   assign m_data  = fifo_out[DW-1:0];
   assign m_last  = fifo_out[DW];
   assign b_en    = {N_BANKS{en_q}};
   assign b_addr  = {N_BANKS{b_addr_q}};

`ifdef BANK_STREAM_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (state_q == IDLE && start) begin
         stall_cycles <= '0;
      end else if (m_valid && !m_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bank_read_streamer.sv
// Randomized bench for bank_read_streamer with a bank memory model and beat scoreboard.
module tb_bank_read_streamer;

   localparam int unsigned NB = 4;
   localparam int unsigned W  = 32;
   localparam int unsigned D  = 16;
   localparam int unsigned RL = 3;
   localparam int unsigned FD = 4;
   localparam int unsigned AW = 4;
   localparam int unsigned DW = NB * W;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [AW-1:0]    base_addr;
   logic [AW:0]      count;
   logic             busy, done;
   logic [NB-1:0]    b_en;
   logic [NB*AW-1:0] b_addr;
   logic [DW-1:0]    b_dout;
   logic             m_valid, m_ready, m_last;
   logic [DW-1:0]    m_data;
`ifdef BANK_STREAM_STALL_CNT_EN
   logic [31:0]      stall_cycles;
`endif

   bank_read_streamer #(
      .N_BANKS(NB), .W(W), .DEPTH_PER_BANK(D), .READ_LATENCY(RL), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
      .busy(busy), .done(done), .b_en(b_en), .b_addr(b_addr), .b_dout(b_dout),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
`ifdef BANK_STREAM_STALL_CNT_EN
      , .stall_cycles(stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else             n_pass++;
   endtask

   function automatic logic [W-1:0] row_word(input int k, input int a);
      return {8'(k), 8'(a), 16'hA55A};
   endfunction

   function automatic logic [DW-1:0] row_beat(input int a);
      logic [DW-1:0] v;
      for (int k = 0; k < NB; k++) v[k*W +: W] = row_word(k, a);
      return v;
   endfunction

   // Bank model: each bank returns its row RL edges after sampling b_en.
   logic [DW-1:0] rd_pipe [RL];
   always @(posedge clk) begin
      logic [DW-1:0] w;
      for (int k = 0; k < NB; k++)
         w[k*W +: W] = b_en[k] ? row_word(k, int'(b_addr[k*AW +: AW])) : '0;
      rd_pipe[0] <= w;
      for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign b_dout = rd_pipe[RL-1];

   logic [AW-1:0] exp_addr [$];
   logic [DW-1:0] exp_data [$];
   logic          exp_last [$];

   int            cyc = 0, rc = 0, mode = 0, low_left = 0, en_seen = 0;
   int            last_pop_cyc = 0, done_cyc = 0;
   bit            done_seen = 0, prev_stall = 0;
   logic [DW-1:0] prev_data;
   logic          prev_last;

   // Drive m_ready for the coming edge, then score what that edge will do.
   always @(negedge clk) begin
      cyc++;
      rc++;
      if (!rst_n) begin
         prev_stall = 0;
      end else begin
         case (mode)
            1: m_ready = (rc < 12) ? ((rc % 2) == 0) : (rc >= 22);
            2: m_ready = 1'($urandom_range(0, 1));
            3: if (m_valid && low_left > 0) begin m_ready = 1'b0; low_left--; end
               else m_ready = 1'b1;
            default: m_ready = 1'b1;
         endcase
         if (prev_stall) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, prev_data);
            check("hold_last", m_last, prev_last);
         end
         if (b_en != '0) begin
            en_seen++;
            check("b_en_uniform", b_en, {NB{1'b1}});
            for (int k = 1; k < NB; k++)
               check("b_addr_uniform", b_addr[k*AW +: AW], b_addr[AW-1:0]);
            if (exp_addr.size() == 0) check("extra_read", 1, 0);
            else check("b_addr", b_addr[AW-1:0], exp_addr.pop_front());
         end
         if (m_valid && m_ready) begin
            if (exp_data.size() == 0) check("extra_beat", 1, 0);
            else begin
               check("m_data", m_data, exp_data.pop_front());
               check("m_last", m_last, exp_last.pop_front());
            end
            last_pop_cyc = cyc;
         end
         if (done) begin
            done_seen = 1;
            done_cyc  = cyc;
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
      end
   end

   task automatic load_expect(input int b, input int c);
      for (int i = 0; i < c; i++) begin
         exp_addr.push_back(AW'((b + i) % D));
         exp_data.push_back(row_beat((b + i) % D));
         exp_last.push_back(i == c - 1);
      end
   endtask

   task automatic pulse_start(input int b, input int c);
      @(posedge clk); #1;
      base_addr = AW'(b);
      count     = (AW+1)'(c);
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_b_en"}, b_en, 0);
      check({tag, "_b_addr"}, b_addr, 0);
      check({tag, "_m_valid"}, m_valid, 0);
      check({tag, "_m_data"}, m_data, 0);
      check({tag, "_m_last"}, m_last, 0);
   endtask

   task automatic run_case(input int b, input int c, input int md, input int lows);
      int t;
      mode      = md;
      low_left  = lows;
      en_seen   = 0;
      done_seen = 0;
      load_expect(b, c);
      pulse_start(b, c);
      rc = 0;
      if (c == 0) begin
         check("zero_done", done, 1);
         check("zero_busy", busy, 0);
      end else begin
         check("first_b_en", b_en, {NB{1'b1}});
         check("run_busy", busy, 1);
      end
      t = 0;
      while (!done_seen && t < 2000) begin
         @(posedge clk); #1;
         t++;
      end
      check("done_timeout", done_seen, 1);
      @(posedge clk); #1;
      check("done_pulse", done, 0);
      check("idle_busy", busy, 0);
      check("reads_issued", en_seen, c);
      check("beats_left", exp_data.size(), 0);
      check("addr_left", exp_addr.size(), 0);
      if (md == 0 && c != 0) check("done_latency", done_cyc - last_pop_cyc, 2);
   endtask

   initial begin
      int t;
      rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; m_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rst_n = 1'b1;

      run_case(0, 16, 0, 0);
      run_case(14, 4, 0, 0);
      run_case(7, 0, 0, 0);
      run_case(2, 8, 1, 0);
      run_case(5, 4, 3, 7);
`ifdef BANK_STREAM_STALL_CNT_EN
      check("stall_cycles", stall_cycles, 7);
`endif
      run_case(15, 1, 0, 0);
      for (int i = 0; i < 6; i++)
         run_case(int'($urandom_range(0, D - 1)), int'($urandom_range(1, D)), 2, 0);

      // Reset in the middle of a run.
      mode    = 0;
      en_seen = 0;
      load_expect(3, 16);
      pulse_start(3, 16);
      t = 0;
      while (en_seen < 5 && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      check("mid_reset_reach", en_seen >= 5, 1);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("mid_reset");
      exp_addr.delete();
      exp_data.delete();
      exp_last.delete();
      done_seen = 0;
      repeat (3) @(posedge clk);
      #1;
      check("mid_reset_no_done", done_seen, 0);
      rst_n = 1'b1;
      run_case(9, 10, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
